// File: rtl/tcvc_pkg.sv
// Shared defaults for the TC/VC interconnect routing blocks.
package tcvc_pkg;
  localparam int   BW_DEFAULT       = 6;
  localparam int   DEST_BIT_DEFAULT = 4;
  localparam int   CNT_W_DEFAULT    = 8;
  localparam logic DEST_D0          = 1'b0;
  localparam logic DEST_D1          = 1'b1;
endpackage

// File: rtl/dest_demux_hold_buf2.sv
// Two-entry synchronous FIFO; entry 0 is always the head so no read pointer is needed.
module hold_buf2 #(
  parameter int BW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [BW-1:0] push_data,
  input  logic          pop,
  output logic [BW-1:0] head,
  output logic [1:0]    cnt
);
  logic [BW-1:0] ent0, ent1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= push_data;
          else             ent1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          ent1 <= '0;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps the count; the new word lands behind whatever remains.
          if (cnt == 2'd2) begin
            ent0 <= ent1;
            ent1 <= push_data;
          end else begin
            ent0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = ent0;

  a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push && !pop && cnt == 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && cnt == 2'd0));
endmodule

// File: rtl/dest_demux.sv
// Pops words from the source FIFO and steers each one to D0 or D1 by its destination bit.
module dest_demux
  import tcvc_pkg::*;
#(
  parameter int BW       = BW_DEFAULT,
  parameter int DEST_BIT = DEST_BIT_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src_empty,
  input  logic [BW-1:0]    src_data,
  output logic             src_rd,
  input  logic             pause,
  input  logic             d0_full,
  input  logic             d1_full,
  output logic             d0_wr,
  output logic             d1_wr,
  output logic [BW-1:0]    d_data_out,
  output logic [CNT_W-1:0] count_d0,
  output logic [CNT_W-1:0] count_d1,
  output logic             idle
);
  logic          inflight;
  logic [1:0]    hold_cnt;
  logic [BW-1:0] head;
  logic          has_word, dest, pop;
  logic [2:0]    credit;

  hold_buf2 #(.BW(BW)) u_hold (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (src_data),
    .pop       (pop),
    .head      (head),
    .cnt       (hold_cnt)
  );

  assign has_word = (hold_cnt != 2'd0);
  assign dest     = head[DEST_BIT];
  // Head-of-line: only the oldest word is ever considered for a write.
  assign pop      = !reset && has_word && ((dest == DEST_D1) ? !d1_full : !d0_full);
  assign d0_wr    = pop && (dest == DEST_D0);
  assign d1_wr    = pop && (dest == DEST_D1);
  assign d_data_out = has_word ? head : '0;

  // Counting this cycle's pop as freed space lets the pipeline sustain one word per cycle.
  assign credit = {1'b0, hold_cnt} + {2'b0, inflight} - {2'b0, pop};
  assign src_rd = !reset && !src_empty && !pause && (credit < 3'd2);

  assign idle = reset ? src_empty : (!has_word && !inflight && src_empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= 1'b0;
      count_d0 <= '0;
      count_d1 <= '0;
    end else begin
      inflight <= src_rd;
      if (d0_wr) count_d0 <= count_d0 + CNT_W'(1);
      if (d1_wr) count_d1 <= count_d1 + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_dest_demux.sv
// Scoreboard bench for dest_demux: source FIFO model, per-destination expected queues, write monitor.
module tb_dest_demux;
  import tcvc_pkg::*;
  localparam int BW = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          src_empty = 1'b1;
  logic [BW-1:0] src_data = '0;
  logic          src_rd;
  logic          pause = 1'b0;
  logic          d0_full = 1'b0;
  logic          d1_full = 1'b0;
  logic          d0_wr, d1_wr, idle;
  logic [BW-1:0] d_data_out;
  logic [CW-1:0] count_d0, count_d1;

  int total = 0;
  int bad   = 0;
  int rd_count = 0;
  logic empty_gate = 1'b0;
  logic [BW-1:0] src_q[$];
  logic [BW-1:0] exp_d0[$];
  logic [BW-1:0] exp_d1[$];
  logic [CW-1:0] exp_c0 = '0;
  logic [CW-1:0] exp_c1 = '0;

  always #5 clk = ~clk;

  dest_demux #(.BW(BW), .DEST_BIT(4), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_empty  (src_empty),
    .src_data   (src_data),
    .src_rd     (src_rd),
    .pause      (pause),
    .d0_full    (d0_full),
    .d1_full    (d1_full),
    .d0_wr      (d0_wr),
    .d1_wr      (d1_wr),
    .d_data_out (d_data_out),
    .count_d0   (count_d0),
    .count_d1   (count_d1),
    .idle       (idle)
  );

  // Source FIFO model: one-cycle read latency, empty flag refreshed mid-cycle.
  always @(posedge clk) begin
    if (src_rd) begin
      rd_count++;
      if (src_q.size() > 0) src_data <= src_q.pop_front();
    end
  end

  always @(negedge clk) src_empty = empty_gate || (src_q.size() == 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [BW-1:0] act);
    total++;
    bad++;
    $display("FAIL %s: got write of %0h expected no write", name, act);
  endtask

  // Monitor: every destination write is matched against its scoreboard queue.
  always @(negedge clk) begin
    #1;
    if (d0_wr) begin
      if (exp_d0.size() == 0) unexpected("d0_extra", d_data_out);
      else check("d0_data", 32'(d_data_out), 32'(exp_d0.pop_front()));
      check("d0_excl", 32'(d1_wr), 32'd0);
    end
    if (d1_wr) begin
      if (exp_d1.size() == 0) unexpected("d1_extra", d_data_out);
      else check("d1_data", 32'(d_data_out), 32'(exp_d1.pop_front()));
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [BW-1:0] w, input logic d);
    src_q.push_back(w);
    if (d) begin exp_d1.push_back(w); exp_c1 = exp_c1 + 1'b1; end
    else   begin exp_d0.push_back(w); exp_c0 = exp_c0 + 1'b1; end
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    do begin
      drive_edge();
      samp();
      n++;
    end while (!(idle && src_q.size() == 0) && n < bound);
    check({name, "_idle"}, 32'(idle && src_q.size() == 0), 32'd1);
    check({name, "_cnt0"}, 32'(count_d0), 32'(exp_c0));
    check({name, "_cnt1"}, 32'(count_d1), 32'(exp_c1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd_h, w0_h, w1_h;
    logic       seen;
    int         r0;
    logic [CW-1:0] c0;
    logic [BW-1:0] w;

    // Reset behaviour
    drive_edge();
    samp();
    check("rst_src_rd", 32'(src_rd), 32'd0);
    check("rst_wr", 32'({d0_wr, d1_wr}), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    drive_edge();
    reset = 1'b0;
    samp();
    check("rst_cnt0", 32'(count_d0), 32'd0);
    check("rst_cnt1", 32'(count_d1), 32'd0);
    check("rst_idle_after", 32'(idle), 32'd1);

    // Back-to-back stream, alternating destinations
    drive_edge();
    push_word(6'h01, 1'b0);
    push_word(6'h12, 1'b1);
    push_word(6'h23, 1'b0);
    push_word(6'h34, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) drive_edge();
      samp();
      rd_h[i] = src_rd;
      w0_h[i] = d0_wr;
      w1_h[i] = d1_wr;
    end
    check("stream_rd", 32'(rd_h), 32'h0F);
    check("stream_d0", 32'(w0_h), 32'h14);
    check("stream_d1", 32'(w1_h), 32'h28);
    check("stream_cnt0", 32'(count_d0), 32'd2);
    check("stream_cnt1", 32'(count_d1), 32'd2);
    check("stream_idle", 32'(idle), 32'd1);

    // Head-of-line blocking on D1
    drive_edge();
    d1_full = 1'b1;
    r0 = rd_count;
    push_word(6'h10, 1'b1);
    push_word(6'h00, 1'b0);
    push_word(6'h21, 1'b0);
    samp();
    seen = d0_wr | d1_wr;
    repeat (8) begin
      drive_edge();
      samp();
      seen |= d0_wr | d1_wr;
    end
    check("hol_no_write", 32'(seen), 32'd0);
    check("hol_reads", 32'(rd_count - r0), 32'd2);
    drive_edge();
    d1_full = 1'b0;
    samp();
    check("hol_rel_d1", 32'(d1_wr), 32'd1);
    drive_edge();
    samp();
    check("hol_rel_d0", 32'(d0_wr), 32'd1);
    wait_idle("hol", 50);

    // Pause with one word in flight
    drive_edge();
    push_word(6'h05, 1'b0);
    push_word(6'h16, 1'b1);
    push_word(6'h07, 1'b0);
    samp();
    check("pause_first_rd", 32'(src_rd), 32'd1);
    r0 = rd_count;
    c0 = count_d0;
    drive_edge();
    pause = 1'b1;
    samp();
    seen = src_rd;
    repeat (6) begin
      drive_edge();
      samp();
      seen |= src_rd;
    end
    check("pause_rd_low", 32'(seen), 32'd0);
    check("pause_reads", 32'(rd_count - r0), 32'd1);
    check("pause_drain", 32'(count_d0), 32'(c0 + 8'd1));
    drive_edge();
    pause = 1'b0;
    wait_idle("pause", 50);

    // Reset with two words held
    drive_edge();
    d0_full = 1'b1;
    d1_full = 1'b1;
    push_word(6'h03, 1'b0);
    push_word(6'h14, 1'b1);
    repeat (4) begin
      drive_edge();
      samp();
    end
    check("rs_hold_full", 32'(dut.hold_cnt), 32'd2);
    drive_edge();
    reset = 1'b1;
    samp();
    check("rs_strobes_in", 32'({src_rd, d0_wr, d1_wr}), 32'd0);
    drive_edge();
    reset = 1'b0;
    d0_full = 1'b0;
    d1_full = 1'b0;
    exp_d0.delete();
    exp_d1.delete();
    exp_c0 = '0;
    exp_c1 = '0;
    samp();
    check("rs_hold_empty", 32'(dut.hold_cnt), 32'd0);
    check("rs_cnt0", 32'(count_d0), 32'd0);
    check("rs_cnt1", 32'(count_d1), 32'd0);
    check("rs_strobes", 32'({d0_wr, d1_wr}), 32'd0);
    seen = 1'b0;
    repeat (5) begin
      drive_edge();
      samp();
      seen |= d0_wr | d1_wr;
    end
    check("rs_no_ghost", 32'(seen), 32'd0);
    check("rs_idle", 32'(idle), 32'd1);

    // 256 writes to D0 wrap the counter
    drive_edge();
    for (int i = 0; i < 256; i++) begin
      w = BW'(i) & 6'h2F;
      push_word(w, 1'b0);
    end
    wait_idle("wrap", 400);
    check("wrap_d0_zero", 32'(count_d0), 32'd0);

    // Toggling empty flag with random backpressure
    for (int n = 0; n < 60; n++) begin
      drive_edge();
      empty_gate = ~empty_gate;
      d0_full = 1'($urandom_range(0, 1));
      d1_full = 1'($urandom_range(0, 1));
      if (n < 40) begin
        w = BW'($urandom);
        push_word(w, w[4]);
      end
      samp();
      check("rand_hold_max", 32'(dut.hold_cnt > 2'd2), 32'd0);
    end
    drive_edge();
    empty_gate = 1'b0;
    d0_full = 1'b0;
    d1_full = 1'b0;
    wait_idle("rand", 500);
    check("rand_d0_left", 32'(exp_d0.size()), 32'd0);
    check("rand_d1_left", 32'(exp_d1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
